// File: rtl/prescaler_multi.sv
// Multi-channel phase-accumulator clock prescaler with blink and RX link indicators.
// Everything runs in the osc domain; rst_n is asynchronous, active-low.
module prescaler_multi #(
  parameter int unsigned          NUM_CH      = 2,
  parameter int unsigned          OSCRATE     = 12_000_000,
  parameter logic [NUM_CH*32-1:0] CH_RATES    = {32'd4800, 32'd1_790_000},
  parameter int unsigned          ACCW        = 24,
  parameter int unsigned          BLINK_HZ    = 1,
  parameter int unsigned          LINK_HOLD   = OSCRATE / 20,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic              osc,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              rx,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              blink,
  output logic              link
);

  localparam int unsigned BlinkHalf = OSCRATE / (2 * BLINK_HZ);
  localparam int unsigned BlinkW    = (BlinkHalf > 1) ? $clog2(BlinkHalf) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BlinkHalf - 1);
  localparam int unsigned LinkW     = (LINK_HOLD > 0) ? $clog2(LINK_HOLD + 1) : 1;
  localparam logic [LinkW-1:0]  LinkLoad  = LinkW'(LINK_HOLD);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("prescaler_multi: NUM_CH must be in 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("prescaler_multi: SYNC_STAGES must be at least 2");
  end
  if (BlinkHalf < 1) begin : g_bad_blink
    $error("prescaler_multi: BLINK_HZ too high for OSCRATE");
  end

  // Clock channels
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam longint unsigned Rate = 64'(CH_RATES[32*i +: 32]);
    localparam longint unsigned Inc  =
        (2 * Rate * (64'd1 << ACCW) + 64'(OSCRATE / 2)) / 64'(OSCRATE);
    localparam logic [ACCW:0] IncW = Inc[ACCW:0];

    if (2 * Rate > 64'(OSCRATE)) begin : g_bad_rate
      $error("prescaler_multi: channel rate exceeds OSCRATE/2");
    end

    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW:0]   sum;
    logic            clk_q, clk_d;
    logic            tick_q, tick_d;

    // Disable takes priority over a coincident carry: output forced low, no tick.
    always_comb begin
      sum    = {1'b0, acc_q} + IncW;
      acc_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      if (en[i]) begin
        acc_d  = sum[ACCW-1:0];
        clk_d  = clk_q ^ sum[ACCW];
        tick_d = sum[ACCW] & ~clk_q;
      end
    end

    always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
        acc_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

  // Blink
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;

  // Link: synchronise rx (idle high), detect either edge, hold with a retriggerable counter
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_edge;
  logic [LinkW-1:0]       link_cnt_q, link_cnt_d;
  logic                   link_q;

  assign rx_edge = sync_q[SYNC_STAGES-1] ^ rx_prev_q;

  always_comb begin
    link_cnt_d = link_cnt_q;
    if (rx_edge) begin
      link_cnt_d = LinkLoad;
    end else if (link_cnt_q != '0) begin
      link_cnt_d = link_cnt_q - LinkW'(1);
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      link_cnt_q <= '0;
      link_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q  <= sync_q[SYNC_STAGES-1];
      link_cnt_q <= link_cnt_d;
      link_q     <= (link_cnt_q != '0);
    end
  end

  assign link = link_q;

endmodule

// File: tb/tb_prescaler_multi.sv
// Bench for prescaler_multi: vector table, hand sequences, random en/rx against a
// carry-count reference model, and a long fractional-rate run.
module tb_prescaler_multi;

  localparam int unsigned AccW  = 16;
  localparam int unsigned HalfA = 6;   // OSCRATE 12, BLINK_HZ 1
  localparam int unsigned HalfB = 10;  // OSCRATE 20, BLINK_HZ 1
  localparam int          SyncA = 2;
  localparam int          HoldA = 10;
  localparam int          RunC  = 40000;

  logic       osc = 1'b0;
  logic       rst_n;
  logic [1:0] en_a;
  logic       rx_a;
  logic [1:0] clk_a, tick_a;
  logic       blink_a, link_a;
  logic       clk_b, tick_b, blink_b, link_b;
  logic       clk_c, tick_c, blink_c, link_c;

  always #5 osc = ~osc;

  // ch0 = 3 Hz, ch1 = 1 Hz
  prescaler_multi #(
    .NUM_CH(2), .OSCRATE(12), .CH_RATES({32'd1, 32'd3}), .ACCW(AccW),
    .BLINK_HZ(1), .LINK_HOLD(HoldA), .SYNC_STAGES(SyncA)
  ) u_dut_a (
    .osc(osc), .rst_n(rst_n), .en(en_a), .rx(rx_a),
    .clk_out(clk_a), .tick(tick_a), .blink(blink_a), .link(link_a)
  );

  prescaler_multi #(
    .NUM_CH(1), .OSCRATE(20), .CH_RATES(32'd5), .ACCW(AccW),
    .BLINK_HZ(1), .LINK_HOLD(10), .SYNC_STAGES(2)
  ) u_dut_b (
    .osc(osc), .rst_n(rst_n), .en(1'b1), .rx(1'b1),
    .clk_out(clk_b), .tick(tick_b), .blink(blink_b), .link(link_b)
  );

  prescaler_multi #(
    .NUM_CH(1), .OSCRATE(12_000_000), .CH_RATES(32'd1_790_000), .ACCW(24),
    .BLINK_HZ(1), .SYNC_STAGES(2)
  ) u_dut_c (
    .osc(osc), .rst_n(rst_n), .en(1'b1), .rx(1'b1),
    .clk_out(clk_c), .tick(tick_c), .blink(blink_c), .link(link_c)
  );

  typedef struct {
    logic [1:0] en;
    logic       rx;
    logic [1:0] clk;
    logic [1:0] tick;
    logic       blink;
  } vec_t;

  vec_t            tbl [12];
  int              total = 0;
  int              bad   = 0;
  int              u;
  int              k [2];
  bit              rxh [0:4095];
  longint unsigned inc_a [2];

  function automatic longint unsigned calc_inc(input longint unsigned rate,
                                               input longint unsigned osc_hz,
                                               input int unsigned w);
    return (2 * rate * (64'd1 << w) + osc_hz / 2) / osc_hz;
  endfunction

  // Number of accumulator wraps after kk enabled cycles from phase 0
  function automatic longint unsigned carries(input int ch, input int kk);
    return (longint'(kk) * inc_a[ch]) >> AccW;
  endfunction

  function automatic logic exp_clk(input int ch);
    longint unsigned c;
    if (k[ch] == 0) return 1'b0;
    c = carries(ch, k[ch]);
    return c[0];
  endfunction

  function automatic logic exp_tick(input int ch);
    longint unsigned c, p;
    if (k[ch] == 0) return 1'b0;
    c = carries(ch, k[ch]);
    p = carries(ch, k[ch] - 1);
    return (c != p) && c[0];
  endfunction

  // High iff some pin-level rx change was sampled in the window that still holds link
  function automatic logic exp_link();
    for (int j = u - SyncA - HoldA; j <= u - SyncA - 1; j++) begin
      if (j >= 1 && rxh[j] != rxh[j-1]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, u, act, exp);
    end
  endtask

  task automatic reset_model();
    u = 0;
    k[0] = 0;
    k[1] = 0;
    for (int i = 0; i < 4096; i++) rxh[i] = 1'b1;
  endtask

  task automatic step(input logic [1:0] e, input logic r);
    en_a = e;
    rx_a = r;
    @(posedge osc);
    u++;
    rxh[u] = r;
    for (int ch = 0; ch < 2; ch++) k[ch] = e[ch] ? k[ch] + 1 : 0;
    @(negedge osc);
    chk("clk_out_a", 32'(clk_a), 32'({exp_clk(1), exp_clk(0)}));
    chk("tick_a", 32'(tick_a), 32'({exp_tick(1), exp_tick(0)}));
    chk("blink_a", 32'(blink_a), 32'((u / HalfA) % 2));
    chk("link_a", 32'(link_a), 32'(exp_link()));
    chk("blink_b", 32'(blink_b), 32'((u / HalfB) % 2));
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].rx);
      chk("tbl_clk", 32'(clk_a), 32'(tbl[i].clk));
      chk("tbl_tick", 32'(tick_a), 32'(tbl[i].tick));
      chk("tbl_blink", 32'(blink_a), 32'(tbl[i].blink));
    end
  endtask

  initial begin
    logic [1:0]      e;
    logic            r;
    int              guard;
    int              ticks, last, bad_gap, first_gap;
    longint unsigned lo;

    //            en     rx    clk    tick   blink
    tbl[0]  = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 2'b01, 2'b01, 1'b0};
    tbl[2]  = '{2'b11, 1'b1, 2'b01, 2'b00, 1'b0};
    tbl[3]  = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[4]  = '{2'b11, 1'b1, 2'b00, 2'b00, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 2'b11, 2'b11, 1'b1};
    tbl[6]  = '{2'b11, 1'b1, 2'b11, 2'b00, 1'b1};
    tbl[7]  = '{2'b11, 1'b1, 2'b10, 2'b00, 1'b1};
    tbl[8]  = '{2'b11, 1'b1, 2'b10, 2'b00, 1'b1};
    tbl[9]  = '{2'b11, 1'b1, 2'b11, 2'b01, 1'b1};
    tbl[10] = '{2'b11, 1'b1, 2'b11, 2'b00, 1'b1};
    tbl[11] = '{2'b00 | 2'b11, 1'b1, 2'b00, 2'b00, 1'b0};

    inc_a[0] = calc_inc(3, 12, AccW);
    inc_a[1] = calc_inc(1, 12, AccW);
    reset_model();

    // Reset state of all instances
    rst_n = 1'b0;
    en_a  = 2'b00;
    rx_a  = 1'b1;
    repeat (3) @(negedge osc);
    chk("rst_clk_a", 32'(clk_a), 32'(0));
    chk("rst_tick_a", 32'(tick_a), 32'(0));
    chk("rst_blink_a", 32'(blink_a), 32'(0));
    chk("rst_link_a", 32'(link_a), 32'(0));
    chk("rst_outs_b", 32'({clk_b, tick_b, blink_b, link_b}), 32'(0));
    chk("rst_outs_c", 32'({clk_c, tick_c, blink_c, link_c}), 32'(0));
    rst_n = 1'b1;

    // Basic ratios: ch0 period 4, ch1 period 12, blink half-period 6
    run_table();

    // en[0] dropped mid-high, then re-enabled; ch1 keeps running
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    step(2'b10, 1'b1);
    chk("drop_clk0", 32'(clk_a[0]), 32'(0));
    chk("drop_tick0", 32'(tick_a[0]), 32'(0));
    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    step(2'b11, 1'b1);
    chk("reen_clk0_1", 32'(clk_a[0]), 32'(0));
    step(2'b11, 1'b1);
    chk("reen_clk0_2", 32'(clk_a[0]), 32'(1));
    chk("reen_tick0_2", 32'(tick_a[0]), 32'(1));

    // Single rx falling edge: link after SYNC_STAGES+2 cycles, for LINK_HOLD cycles
    for (int n = 1; n <= 16; n++) begin
      step(2'b11, 1'b0);
      if (n == 3)  chk("link_pre", 32'(link_a), 32'(0));
      if (n == 4)  chk("link_first", 32'(link_a), 32'(1));
      if (n == 13) chk("link_last", 32'(link_a), 32'(1));
      if (n == 14) chk("link_off", 32'(link_a), 32'(0));
    end

    // Retrigger: second edge 5 cycles after the first
    for (int n = 1; n <= 22; n++) begin
      step(2'b11, (n < 6) ? 1'b1 : 1'b0);
      if (n == 4)  chk("retrig_first", 32'(link_a), 32'(1));
      if (n == 14) chk("retrig_held", 32'(link_a), 32'(1));
      if (n == 18) chk("retrig_last", 32'(link_a), 32'(1));
      if (n == 19) chk("retrig_off", 32'(link_a), 32'(0));
    end

    // Asynchronous reset mid-period with clk_out[0] and link high
    for (int n = 0; n < 6; n++) step(2'b11, 1'b1);
    guard = 0;
    while (exp_clk(0) == 1'b0 && guard < 8) begin
      step(2'b11, 1'b1);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk_a", 32'(clk_a), 32'(0));
    chk("arst_tick_a", 32'(tick_a), 32'(0));
    chk("arst_link_a", 32'(link_a), 32'(0));
    chk("arst_blink_a", 32'(blink_a), 32'(0));
    @(negedge osc);
    @(negedge osc);
    rx_a  = 1'b1;
    rst_n = 1'b1;
    reset_model();
    run_table();

    // Random enables and rx activity against the reference model
    e = 2'b11;
    r = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) e[0] = ~e[0];
      if ($urandom_range(0, 7) == 0) e[1] = ~e[1];
      if ($urandom_range(0, 15) == 0) r = ~r;
      step(e, r);
    end

    // Fractional ratio 12 MHz -> 1.79 MHz: tick count and spacing
    ticks     = 0;
    last      = -1;
    bad_gap   = 0;
    first_gap = 0;
    for (int c = 1; c <= RunC; c++) begin
      @(posedge osc);
      #1;
      if (tick_c) begin
        if (last >= 0 && (c - last < 6 || c - last > 7)) begin
          bad_gap++;
          if (first_gap == 0) first_gap = c - last;
        end
        last = c;
        ticks++;
      end
    end
    lo = (longint'(RunC) * 1_790_000) / 12_000_000;
    total++;
    if (longint'(ticks) < lo || longint'(ticks) > lo + 1) begin
      bad++;
      $display("FAIL frac_tick_count got=%0d want=%0d..%0d", ticks, lo, lo + 1);
    end
    total++;
    if (bad_gap != 0) begin
      bad++;
      $display("FAIL frac_tick_gap got=%0d bad gaps (first=%0d) want=0", bad_gap, first_gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
